// File: rtl/bcd_score_display_if.sv
// Game-logic side of the BCD score display: score events in, score/flags and
// multiplexed seven-segment drive out. Width follows the DIGITS parameter.
interface bcd_score_display_if #(
  parameter int DIGITS = 4
);
  logic                  score_valid;
  logic [3:0]            score_amt;
  logic                  clear;
  logic                  game_end;
  logic [4*DIGITS-1:0]   score_bcd;
  logic                  overflow;
  logic [DIGITS-1:0]     select;
  logic [6:0]            seg;

  modport master (
    output score_valid, score_amt, clear, game_end,
    input  score_bcd, overflow, select, seg
  );

  modport slave (
    input  score_valid, score_amt, clear, game_end,
    output score_bcd, overflow, select, seg
  );
endinterface

// File: rtl/bcd_score_display.sv
// Packed-BCD score accumulator with a scanned common-anode seven-segment bank.
// Define BCD_SCORE_SATURATE_EN to saturate at all-9s on overflow instead of wrapping.
module bcd_score_display #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 17,
  parameter int LZ_BLANK = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bcd_score_display_if.slave   bus
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [4*DIGITS-1:0] score_q, score_d;
  logic                overflow_q, overflow_d;
  logic [SCAN_DIV-1:0] presc_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DIGITS-1:0]   select_q;
  logic [6:0]          seg_q;

  logic [3:0]          amt_clamped;
  logic [DIGITS:0]     carry;
  logic [4*DIGITS-1:0] sum_bcd;
  logic [DIGITS:1]     upper_zero;
  logic [DIGITS-1:0]   sel_d;
  logic [3:0]          cur_digit;
  logic                cur_blank;
  logic [6:0]          seg_d;
  logic                presc_wrap;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign amt_clamped   = (bus.score_amt > 4'd9) ? 4'd9 : bus.score_amt;
  assign carry[0]      = 1'b0;
  assign upper_zero[DIGITS] = 1'b1;

  // One BCD adder cell per digit; only digit 0 receives the amount, the rest ripple the carry.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] addend;
      logic [4:0] raw;
      assign addend = (gi == 0) ? amt_clamped : 4'd0;
      assign raw    = {1'b0, score_q[4*gi +: 4]} + {1'b0, addend} + {4'd0, carry[gi]};
      assign carry[gi+1] = (raw > 5'd9);
      assign sum_bcd[4*gi +: 4] = carry[gi+1] ? 4'(raw - 5'd10) : raw[3:0];
      assign sel_d[gi] = (idx_q != IDX_W'(gi));
    end
    for (gi = 1; gi < DIGITS; gi++) begin : g_lz
      assign upper_zero[gi] = upper_zero[gi+1] & (score_q[4*gi +: 4] == 4'd0);
    end
  endgenerate

`ifdef BCD_SCORE_SATURATE_EN
  logic [4*DIGITS-1:0] nines;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_nines
      assign nines[4*gi +: 4] = 4'd9;
    end
  endgenerate
`endif

  always_comb begin
    score_d    = score_q;
    overflow_d = overflow_q;
    if (bus.clear) begin
      score_d    = '0;
      overflow_d = 1'b0;
    end else if (!bus.game_end && bus.score_valid) begin
      score_d = sum_bcd;
      if (carry[DIGITS]) begin
        overflow_d = 1'b1;
`ifdef BCD_SCORE_SATURATE_EN
        score_d = nines;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      score_q    <= score_d;
      overflow_q <= overflow_d;
    end
  end

  assign presc_wrap = &presc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      presc_q <= presc_q + SCAN_DIV'(1);
      if (presc_wrap) begin
        idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      end
    end
  end

  // Digit 0 is never blanked, so the search starts at position 1.
  always_comb begin
    cur_digit = score_q[3:0];
    cur_blank = 1'b0;
    for (int i = 1; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_digit = score_q[4*i +: 4];
        cur_blank = (LZ_BLANK != 0) && upper_zero[i];
      end
    end
  end

  assign seg_d = cur_blank ? 7'h7F : seg_decode(cur_digit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      select_q <= '1;
      seg_q    <= 7'h7F;
    end else begin
      select_q <= sel_d;
      seg_q    <= seg_d;
    end
  end

  assign bus.score_bcd = score_q;
  assign bus.overflow  = overflow_q;
  assign bus.select    = select_q;
  assign bus.seg       = seg_q;

endmodule

// File: tb/tb_bcd_score_display.sv
// Randomized scoreboard bench for bcd_score_display: two instances (4-digit blanked,
// 2-digit unblanked) checked against an integer-arithmetic model of score and scan.
module tb_bcd_score_display;

  localparam int D1 = 4, SD1 = 3, LZ1 = 1;
  localparam int D2 = 2, SD2 = 2, LZ2 = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic txn = 1'b0;

  bcd_score_display_if #(.DIGITS(D1)) b1 ();
  bcd_score_display_if #(.DIGITS(D2)) b2 ();

  bcd_score_display #(.DIGITS(D1), .SCAN_DIV(SD1), .LZ_BLANK(LZ1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave));
  bcd_score_display #(.DIGITS(D2), .SCAN_DIV(SD2), .LZ_BLANK(LZ2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2.slave));

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] s1; logic o1; logic [3:0] sel1; logic [6:0] seg1;
    logic [7:0]  s2; logic o2; logic [1:0] sel2; logic [6:0] seg2;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int total = 0;
  int bad = 0;
  int m1, m2, n;
  bit o1, o2;
  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic int pow10(input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [31:0] to_bcd(input int v, input int d);
    logic [31:0] r = '0;
    for (int i = 0; i < d; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  function automatic logic [7:0] exp_sel(input int idx);
    logic [7:0] r = '1;
    r[idx] = 1'b0;
    return r;
  endfunction

  // A digit above 0 is blank exactly when the whole score is below 10^idx.
  function automatic logic [6:0] exp_seg(input int v, input int idx, input int lz);
    if (lz != 0 && idx > 0 && v < pow10(idx)) return 7'h7F;
    return seg_tab[(v / pow10(idx)) % 10];
  endfunction

  task automatic model_apply(inout int m, inout bit o, input bit v, input logic [3:0] a,
                             input bit c, input bit g, input int d);
    int lim;
    lim = pow10(d) - 1;
    if (c) begin
      m = 0;
      o = 1'b0;
    end else if (!g && v) begin
      m = m + ((a > 4'd9) ? 9 : int'(a));
      if (m > lim) begin
        o = 1'b1;
`ifdef BCD_SCORE_SATURATE_EN
        m = lim;
`else
        m = m - (lim + 1);
`endif
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Called at a negedge: drives one cycle of stimulus and queues the response due at the next posedge.
  task automatic step(input bit v, input logic [3:0] a, input bit c, input bit g,
                      input bit v2, input logic [3:0] a2);
    exp_t e;
    int i1, i2;
    b1.score_valid = v;  b1.score_amt = a;  b1.clear = c; b1.game_end = g;
    b2.score_valid = v2; b2.score_amt = a2; b2.clear = c; b2.game_end = g;
    txn = 1'b1;
    n++;
    i1 = ((n - 1) >> SD1) % D1;
    i2 = ((n - 1) >> SD2) % D2;
    e.sel1 = 4'(exp_sel(i1));
    e.seg1 = exp_seg(m1, i1, LZ1);
    e.sel2 = 2'(exp_sel(i2));
    e.seg2 = exp_seg(m2, i2, LZ2);
    model_apply(m1, o1, v, a, c, g, D1);
    model_apply(m2, o2, v2, a2, c, g, D2);
    e.s1 = 16'(to_bcd(m1, D1));
    e.o1 = o1;
    e.s2 = 8'(to_bcd(m2, D2));
    e.o2 = o2;
    q.push_back(e);
    $display("txn %0d: valid=%0b amt=%0d clear=%0b game_end=%0b -> score1=%0d score2=%0d",
             n, v, a, c, g, m1, m2);
    @(negedge clk);
  endtask

  task automatic idle_stop();
    b1.score_valid = 1'b0; b1.score_amt = 4'd0; b1.clear = 1'b0; b1.game_end = 1'b0;
    b2.score_valid = 1'b0; b2.score_amt = 4'd0; b2.clear = 1'b0; b2.game_end = 1'b0;
    txn = 1'b0;
  endtask

  task automatic load(input int val);
    int rem;
    rem = val;
    step(0, 4'd0, 1, 0, 0, 4'd0);
    while (rem >= 9) begin
      step(1, 4'd9, 0, 0, 0, 4'd0);
      rem = rem - 9;
    end
    if (rem > 0) step(1, 4'(rem), 0, 0, 0, 4'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_score1"}, 32'(b1.score_bcd), 32'h0);
    chk({tag, "_ovf1"},   32'(b1.overflow),  32'h0);
    chk({tag, "_sel1"},   32'(b1.select),    32'hF);
    chk({tag, "_seg1"},   32'(b1.seg),       32'h7F);
    chk({tag, "_score2"}, 32'(b2.score_bcd), 32'h0);
    chk({tag, "_ovf2"},   32'(b2.overflow),  32'h0);
    chk({tag, "_sel2"},   32'(b2.select),    32'h3);
    chk({tag, "_seg2"},   32'(b2.seg),       32'h7F);
  endtask

  task automatic model_reset();
    m1 = 0; m2 = 0; o1 = 1'b0; o2 = 1'b0; n = 0;
  endtask

  always @(posedge clk) begin
    if (txn) begin
      #1;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty: got no entry expected one (t=%0t)", $time);
      end else begin
        mon_e = q.pop_front();
        chk("score1", 32'(b1.score_bcd), 32'(mon_e.s1));
        chk("ovf1",   32'(b1.overflow),  32'(mon_e.o1));
        chk("sel1",   32'(b1.select),    32'(mon_e.sel1));
        chk("seg1",   32'(b1.seg),       32'(mon_e.seg1));
        chk("score2", 32'(b2.score_bcd), 32'(mon_e.s2));
        chk("ovf2",   32'(b2.overflow),  32'(mon_e.o2));
        chk("sel2",   32'(b2.select),    32'(mon_e.sel2));
        chk("seg2",   32'(b2.seg),       32'(mon_e.seg2));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_stop();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset("por");

    @(negedge clk);
    rst_n = 1'b1;
    step(1, 4'd1, 0, 0, 1, 4'd7);
    repeat (4) step(1, 4'd1, 0, 0, 0, 4'd0);
    repeat (70) step(0, 4'd0, 0, 0, 0, 4'd0);

    repeat (200)
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));

    load(97);
    step(1, 4'd7, 0, 0, 0, 4'd0);
    load(97);
    step(1, 4'd15, 0, 0, 0, 4'd0);

    load(9998);
    step(1, 4'd5, 0, 0, 1, 4'd9);
    step(1, 4'd5, 0, 0, 0, 4'd0);
    step(1, 4'd0, 0, 0, 0, 4'd0);
    step(0, 4'd0, 1, 0, 0, 4'd0);
    step(0, 4'd0, 0, 0, 0, 4'd0);

    load(42);
    repeat (3) begin
      step(1, 4'd9, 0, 1, 1, 4'd9);
      step(0, 4'd0, 0, 1, 0, 4'd0);
    end
    step(1, 4'd3, 0, 0, 0, 4'd0);
    step(1, 4'd4, 1, 0, 1, 4'd4);
    step(0, 4'd0, 0, 0, 0, 4'd0);

    // Asynchronous reset landing between edges while an update is being presented.
    load(321);
    step(0, 4'd0, 0, 0, 1, 4'd6);
    idle_stop();
    b1.score_valid = 1'b1;
    b1.score_amt   = 4'd5;
    #2 rst_n = 1'b0;
    #1 chk_reset("rst_update");
    idle_stop();
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;

    step(1, 4'd8, 0, 0, 1, 4'd3);
    repeat (12) step(0, 4'd0, 0, 0, 0, 4'd0);
    idle_stop();
    #3 rst_n = 1'b0;
    #1 chk_reset("rst_scan");
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    step(1, 4'd2, 0, 0, 1, 4'd1);
    repeat (40) step(0, 4'd0, 0, 0, 0, 4'd0);
    idle_stop();

    @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_score_display.md
Name: bcd_score_display

Overview:
- Parametrised successor to the fixed 4-digit score display.
- Holds a DIGITS-wide packed-BCD score. Adds a variable amount (0-9) per synchronous score event, with a single-cycle BCD carry chain.
- Drives a time-multiplexed common-anode seven-segment bank with optional leading-zero blanking.
- Sits between game logic (score events, clear, game_end) and the board display pins.

Parameters:
- DIGITS, 4, number of BCD digits and scanned display positions (1..8).
- SCAN_DIV, 17, width of the refresh prescaler; each digit is shown for 2^SCAN_DIV clk cycles.
- LZ_BLANK, 1, 1 = blank leading zero digits (digit 0 is always shown); 0 = show all digits.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- score_valid  in  1  single-cycle score event, synchronous to clk.
- score_amt  in  4  amount to add on score_valid; values 10-15 are clamped to 9.
- clear  in  1  synchronous score clear.
- game_end  in  1  level; while high, score events are ignored.
- score_bcd  out  4*DIGITS  registered packed BCD score; digit 0 is in bits [3:0].
- overflow  out  1  sticky flag: the score exceeded 10^DIGITS-1.
- select  out  DIGITS  one-hot active-low digit enable.
- seg  out  7  active-low segments {g,f,e,d,c,b,a}.

Behaviour:
- Reset (rst_n low, asynchronous):
  - score_bcd = 0, overflow = 0.
  - Prescaler = 0, scan index = 0.
  - select = all ones (all digits off), seg = 7'h7F.
- Priority each clk edge: clear > game_end > score_valid.
- clear:
  - score_bcd <= 0 and overflow <= 0 on the next edge.
  - A score_valid in the same cycle is dropped.
- Score update:
  - Condition: score_valid=1, game_end=0, clear=0.
  - score_bcd <= score_bcd + min(score_amt,9), computed digit-wise in BCD with ripple carry in one cycle.
  - Latency: 1 cycle, valid on score_bcd the edge after score_valid.
  - Each digit stays in 0..9 at all times.
  - score_valid with score_amt=0 leaves the score unchanged.
- Overflow (carry out of the top digit):
  - overflow <= 1.
  - The result follows the Optional Feature rule.
- Events while game_end=1 are lost; they are not queued.
- Scan:
  - The prescaler free-runs.
  - On prescaler wrap (all ones -> 0), the scan index advances 0..DIGITS-1, then wraps to 0.
  - select and seg are registered; they update 1 cycle after the index changes.
  - Selected digit: select[idx]=0, all other bits 1.
  - seg = decode(score_bcd digit idx).
- Leading-zero blanking (LZ_BLANK=1):
  - A digit idx>0 is blanked (seg=7'h7F, select still asserted) when it and every higher digit are 0.
- Segment decode for 0-9 (active-low, {g..a}): 40,79,24,30,19,12,02,78,00,10 (hex).
- The decode path is unreachable for values >9; it outputs 7'h7F.
- Reset mid-scan: the scan restarts at digit 0 after rst_n deasserts, with a full prescaler period before the first advance.

Optional Feature:
- Macro: BCD_SCORE_SATURATE_EN.
- Defined:
  - On overflow, score_bcd saturates at all-9s (e.g. 9999 for DIGITS=4).
  - Further events hold at all-9s; overflow is set.
- Undefined:
  - Score wraps modulo 10^DIGITS (9998+5 -> 0003) and overflow is set.
- In both cases, overflow clears only on clear or reset.

Test Plan:
- Reset, then five score_valid pulses with amt=1 -> score_bcd=16'h0005, overflow=0; select cycles 1110,1101,1011,0111 every 2^SCAN_DIV cycles. With LZ_BLANK=1, digits 1-3 show seg=7F and digit 0 shows 12.
- Score 0x0097, then valid with amt=7 -> next cycle 16'h0104; with amt=15 (clamped to 9) -> 16'h0106 instead.
- Score 0x9998, then valid with amt=5 -> with BCD_SCORE_SATURATE_EN: 16'h9999, overflow=1; without: 16'h0003, overflow=1. Then clear -> 0, overflow=0.
- game_end=1 with three valid pulses -> score unchanged. clear and valid in the same cycle -> score=0.
- Assert rst_n low mid-update and mid-scan -> outputs immediately at reset values without waiting for clk. After release, digit 0 is selected first.
- DIGITS=2, SCAN_DIV=2, LZ_BLANK=0: score 07 -> seg alternates 40 (digit 1) / 78 (digit 0), 4 cycles each.
